// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage feeding decode.
// Keeps the PC and issues in-order word fetches. Returned words go into a
// DEPTH-entry prefetch FIFO, and each word is tagged with the address it was
// fetched from. A redirect flushes the FIFO and drops responses still in flight.
// Optional feature: define IFETCH_STALL_CNT_EN to add the stall_cnt output,
// which counts decode-starved cycles.
module ifetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  input  logic        halt,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        cnt,
  input  logic        dec_ready
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALTED, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, fcnt_q, fcnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]   inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   tag_mem_q  [DEPTH];

  logic [CW:0]   occ;
  logic          issue, push, pop, redir_act;
  logic [CW-1:0] redir_disc;

  // Handshake decode: issue gating, FIFO push/pop and redirect qualification.
  always_comb begin
    redir_act  = redir && (state_q != BOOT);
    occ        = {1'b0, fcnt_q} + {1'b0, out_q};
    imem_req   = (state_q == RUN) && !halt && !redir_act && (occ < DEPTH_V);
    issue      = imem_req && imem_gnt;
    pop        = (fcnt_q != '0) && dec_ready;
    // A word returning on a redirect cycle belongs to the old stream.
    push       = imem_rvalid && !redir_act && ((state_q == RUN) || (state_q == HALTED));
    redir_disc = out_q - CW'(imem_rvalid);
  end

  // Next-state for PC, counters, FIFO pointers, head register and FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    disc_d    = disc_q;
    fcnt_d    = fcnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    out_d = out_q + CW'(issue) - CW'(imem_rvalid);
    if (issue) begin
      pc_d     = pc_q + 32'd4;
      tag_wr_d = tag_wr_q + PW'(1);
    end
    // Every response consumes its tag, including the responses that get dropped.
    if (imem_rvalid) tag_rd_d = tag_rd_q + PW'(1);

    if (redir_act) begin
      pc_d   = redir_pc;
      fcnt_d = '0;
      wr_d   = '0;
      rd_d   = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
      // The head is registered. When the FIFO would otherwise be empty,
      // the incoming word goes straight into the head register.
      if (fcnt_d != '0) begin
        if ((fcnt_q - CW'(pop)) == '0) begin
          inst_d    = imem_rdata;
          inst_pc_d = tag_mem_q[tag_rd_q];
        end else begin
          inst_d    = data_mem_q[rd_d];
          inst_pc_d = pc_mem_q[rd_d];
        end
      end
    end

    case (state_q)
      BOOT: state_d = RUN;
      RUN, HALTED: begin
        if (redir_act) begin
          disc_d  = redir_disc;
          state_d = (redir_disc != '0) ? FLUSH : RUN;
        end else if ((state_q == RUN) && halt) begin
          state_d = HALTED;
        end else if ((state_q == HALTED) && !halt) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // A further redirect only reloads the PC; the discard count is unchanged.
        disc_d = disc_q - CW'(imem_rvalid);
        if (disc_d == '0) state_d = halt ? HALTED : RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Control and head registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
      fcnt_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
      fcnt_q    <= fcnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Storage for the word FIFO and the in-flight address tags (not reset).
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_q] <= imem_rdata;
      pc_mem_q[wr_q]   <= tag_mem_q[tag_rd_q];
    end
    if (issue) tag_mem_q[tag_wr_q] <= pc_q;
  end

  // The issue rule makes overflow impossible; this guards that invariant.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && (fcnt_q == FULL)));
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count cycles where decode is starved while not halted; saturates.
  always_comb begin
    stall_d = stall_q;
    if ((state_q != BOOT) && (fcnt_q == '0) && !halt && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign cnt       = (fcnt_q != '0);

endmodule
